guess_checker: RTL
==================

GUESS_CHECKER -- requirements
Module: guess_checker

Interface
REQ-001 Parameter WIDTH, default 4, bit width of target and guess numbers (>=1).
REQ-002 Parameter MAX_TRIES, default 8, guesses allowed per round (>=1).
REQ-003 Parameter TW, default $clog2(MAX_TRIES+1), tries counter width (derived, not overridden).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  begin new round; latch target.
REQ-007 target  input  WIDTH  secret number; sampled only when start accepted.
REQ-008 guess  input  WIDTH  player guess; sampled when guess_valid accepted.
REQ-009 guess_valid  input  1  one-cycle strobe: guess present.
REQ-010 result_valid  output  1  one-cycle pulse: new compare result.
REQ-011 match  output  1  last accepted guess == target.
REQ-012 too_high  output  1  last accepted guess > target (unsigned).
REQ-013 too_low  output  1  last accepted guess < target (unsigned).
REQ-014 tries  output  TW  guesses accepted this round.
REQ-015 win  output  1  round ended by match; level.
REQ-016 lose  output  1  round ended by exhausting MAX_TRIES without match; level.
REQ-017 playing  output  1  high in PLAY state.

Function
REQ-018 FSM states IDLE, PLAY, WIN, LOSE; reset state IDLE.
REQ-019 start accepted in any state, incl. PLAY: next cycle state=PLAY, target latched, tries=0, match/too_high/too_low/win/lose=0.
REQ-020 start and guess_valid in same cycle: start wins, guess discarded, no result_valid.
REQ-021 guess_valid accepted only in PLAY; ignored in IDLE/WIN/LOSE (no pulse, no counter change).
REQ-022 Accepted guess: compare against latched target, results registered, result_valid pulses next cycle (latency 1).
REQ-023 Exactly one of match/too_high/too_low high after a result; values held until next result or start/reset.
REQ-024 tries increments by 1 per accepted guess, same cycle as result_valid; never exceeds MAX_TRIES.
REQ-025 Accepted guess equal to target: next state WIN, regardless of tries count.
REQ-026 Accepted non-matching guess with tries+1 == MAX_TRIES: next state LOSE.
REQ-027 Match on final allowed try: WIN, not LOSE.
REQ-028 win/lose asserted same cycle as the ending result_valid; held until start or rst.
REQ-029 Comparison unsigned, full WIDTH; target input changes outside start accept have no effect.
REQ-030 Back-to-back guess_valid every cycle supported; one result per accepted guess.

Reset
REQ-031 rst high at any clock edge, incl. mid-round: state=IDLE, target latch=0, tries=0, all outputs 0.
REQ-032 rst overrides start and guess_valid in same cycle.

Structure
REQ-033 Shared package game_pkg holds state encoding (IDLE, PLAY, WIN, LOSE) and a compare result type {EQ, GT, LT}.
REQ-034 One combinational sub-module num_compare (parameter WIDTH; outputs eq, gt, lt), instantiated once; FSM, counter, output registers in guess_checker.

Verification
REQ-035 WIDTH=4, MAX_TRIES=3: start target=9; guesses 3,12,9 -> too_low,too_high,match; tries 1,2,3; win on 3rd result; lose=0.
REQ-036 MAX_TRIES=3, target=5: guesses 1,2,3 -> three too_low, tries=3, lose=1; further guess_valid -> no result_valid, tries stays 3.
REQ-037 target=7, guess 7 on 3rd try with MAX_TRIES=3 -> win=1, lose=0.
REQ-038 In PLAY with tries=2: start (target=0) and guess_valid same cycle -> no result_valid, tries=0, playing=1, flags 0.
REQ-039 rst mid-round after 1 guess -> next cycle IDLE, all outputs 0; guess_valid then ignored until start.
REQ-040 WIDTH=8: target=255, guess 0 -> too_low; guess 255 -> match; guesses on consecutive cycles give consecutive result_valid pulses.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types for the guessing game: FSM state encoding and compare outcome.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    EQ = 2'd0,
    GT = 2'd1,
    LT = 2'd2
  } cmp_t;

  // Collapse the three compare strobes into a single outcome code.
  function automatic cmp_t to_cmp(input logic eq, input logic gt);
    if (eq) begin
      return EQ;
    end else if (gt) begin
      return GT;
    end
    return LT;
  endfunction

endpackage

// File: rtl/num_compare.sv
// Unsigned full-width magnitude compare of a guess against a target.
module num_compare #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  // Exactly one of eq/gt/lt is high for any pair of inputs.
  always_comb begin
    eq = (a == b);
    gt = (a > b);
    lt = (a < b);
  end

endmodule

// File: rtl/guess_checker.sv
// Number-guessing round controller: latches a target on start, grades each
// accepted guess, counts tries and ends the round in WIN or LOSE.
//
// Strobe semantics: start and guess_valid are single-cycle strobes with no
// back-pressure. start is accepted in every state; guess_valid is accepted
// only in PLAY and only when start is low. result_valid pulses for one cycle,
// one cycle after each accepted guess. rst overrides everything.
module guess_checker
  import game_pkg::*;
#(
  parameter  int WIDTH     = 4,
  parameter  int MAX_TRIES = 8,
  localparam int TW        = $clog2(MAX_TRIES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] guess,
  input  logic             guess_valid,
  output logic             result_valid,
  output logic             match,
  output logic             too_high,
  output logic             too_low,
  output logic [TW-1:0]    tries,
  output logic             win,
  output logic             lose,
  output logic             playing
);

  state_t           state, state_n;
  logic [WIDTH-1:0] target_q, target_n;
  logic [TW-1:0]    tries_q, tries_n, tries_inc;
  logic             rv_q, rv_n;
  logic             match_q, match_n;
  logic             high_q, high_n;
  logic             low_q, low_n;
  logic             cmp_eq, cmp_gt, cmp_lt;
  cmp_t             cmp;

  num_compare #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .a  (guess),
    .b  (target_q),
    .eq (cmp_eq),
    .gt (cmp_gt),
    .lt (cmp_lt)
  );

  // Next-state, counter and result-flag logic; start takes priority over a guess.
  always_comb begin
    state_n   = state;
    target_n  = target_q;
    tries_n   = tries_q;
    rv_n      = 1'b0;
    match_n   = match_q;
    high_n    = high_q;
    low_n     = low_q;
    tries_inc = tries_q + TW'(1);
    cmp       = to_cmp(cmp_eq, cmp_gt);
    if (start) begin
      state_n  = PLAY;
      target_n = target;
      tries_n  = '0;
      match_n  = 1'b0;
      high_n   = 1'b0;
      low_n    = 1'b0;
    end else if (guess_valid && state == PLAY) begin
      rv_n    = 1'b1;
      tries_n = tries_inc;
      match_n = 1'b0;
      high_n  = 1'b0;
      low_n   = 1'b0;
      case (cmp)
        EQ:      match_n = 1'b1;
        GT:      high_n  = 1'b1;
        default: low_n   = 1'b1;
      endcase
      // A match always wins, even on the last allowed try.
      if (cmp == EQ) begin
        state_n = WIN;
      end else if (tries_inc == TW'(MAX_TRIES)) begin
        state_n = LOSE;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      target_q <= '0;
      tries_q  <= '0;
      rv_q     <= 1'b0;
      match_q  <= 1'b0;
      high_q   <= 1'b0;
      low_q    <= 1'b0;
    end else begin
      state    <= state_n;
      target_q <= target_n;
      tries_q  <= tries_n;
      rv_q     <= rv_n;
      match_q  <= match_n;
      high_q   <= high_n;
      low_q    <= low_n;
    end
  end

  // Round status is decoded directly from the registered state.
  always_comb begin
    result_valid = rv_q;
    match        = match_q;
    too_high     = high_q;
    too_low      = low_q;
    tries        = tries_q;
    win          = (state == WIN);
    lose         = (state == LOSE);
    playing      = (state == PLAY);
  end

endmodule
